// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic MAC array:
// FSM state encoding and width/timing helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // Full signed product width plus headroom for N accumulations.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  // Cycle index of the final MAC, performed by PE(N-1,N-1).
  function automatic int last_cycle(input int n);
    return 3 * n - 3;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: forwards a right and b down, accumulates a*b in place.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 34
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [WIDTH-1:0]     a_in,
  input  logic signed [WIDTH-1:0]     b_in,
  output logic signed [WIDTH-1:0]     a_reg,
  output logic signed [WIDTH-1:0]     b_reg,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a_in * b_in;

  // NOTE: sequential state uses non-blocking assignments so every PE samples
  // its neighbour's value from before the edge, which is what makes data ripple.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else if (en) begin
      a_reg <= a_in;
      b_reg <= b_in;
      acc   <= acc + ACC_WIDTH'(prod);  // signed cast sign-extends; sum wraps
    end
  end

endmodule

// File: rtl/systolic_array.sv
// N x N output-stationary systolic array computing C = A x B from skewed
// row/column streams; result is held from the done pulse until the next start.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N         = 3,
  parameter int ACC_WIDTH = acc_width(WIDTH, N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     row_in [N],
  input  logic signed [WIDTH-1:0]     col_in [N],
  output logic                        busy,
  output logic                        done,
  output logic signed [ACC_WIDTH-1:0] result [N][N]
);

  localparam int CNT_W = $clog2(3 * N);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pe_en;
  logic             pe_clr;

  logic signed [WIDTH-1:0] row_m [N];
  logic signed [WIDTH-1:0] col_m [N];
  logic signed [WIDTH-1:0] a_reg [N][N];
  logic signed [WIDTH-1:0] b_reg [N][N];

  assign pe_en  = (state == COMPUTE);
  assign pe_clr = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= COMPUTE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(last_cycle(N))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Lane i only carries live data in cycles i..i+N-1; anything the upstream
  // block holds outside that window is replaced by zero.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_m[i] = '0;
      col_m[i] = '0;
      if ((int'(cnt) >= i) && (int'(cnt) <= i + N - 1)) begin
        row_m[i] = row_in[i];
        col_m[i] = col_in[i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [WIDTH-1:0] a_in;
      logic signed [WIDTH-1:0] b_in;

      if (j == 0) begin : g_a_edge
        assign a_in = row_m[i];
      end else begin : g_a_int
        assign a_in = a_reg[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = col_m[j];
      end else begin : g_b_int
        assign b_in = b_reg[i-1][j];
      end

      systolic_pe #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pe_en),
        .clr  (pe_clr),
        .a_in (a_in),
        .b_in (b_in),
        .a_reg(a_reg[i][j]),
        .b_reg(b_reg[i][j]),
        .acc  (result[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: acts as the skewing orchestrator and
// compares against a plain matrix-multiply reference.
module tb_systolic_array;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int AW = 2 * W + $clog2(N);

  typedef int mat_t [N][N];

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic signed [W-1:0]  row_in [N];
  logic signed [W-1:0]  col_in [N];
  logic                 busy;
  logic                 done;
  logic signed [AW-1:0] result [N][N];

  int checks   = 0;
  int failures = 0;

  systolic_array #(
    .WIDTH(W),
    .N    (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .row_in(row_in),
    .col_in(col_in),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C = A x B with ordinary integer arithmetic, reduced to AW bits.
  function automatic logic [AW-1:0] ref_c(input mat_t a, input mat_t b, input int i, input int j);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(a[i][k]) * longint'(b[k][j]);
    return s[AW-1:0];
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = int'($signed(16'($urandom)));
    return m;
  endfunction

  function automatic mat_t fill_mat(input int v);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t ident(input int s);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = (i == j) ? s : 0;
    return m;
  endfunction

  task automatic check_result(input string tag, input mat_t a, input mat_t b);
    logic [AW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = result[i][j];
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(r), 64'(ref_c(a, b, i, j)));
      end
  endtask

  task automatic check_zero(input string tag);
    logic [AW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = result[i][j];
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(r), 64'(0));
      end
  endtask

  // Orchestrator emulation: in cycle c lane i carries A[i][c-i] / B[c-i][i];
  // outside that window it carries 0 (fill 0), 5 after the window (fill 1)
  // or random junk (fill 2).
  task automatic drive_lanes(input mat_t a, input mat_t b, input int c, input int fill);
    int k;
    for (int i = 0; i < N; i++) begin
      k = c - i;
      if (k >= 0 && k < N) begin
        row_in[i] = W'(a[i][k]);
        col_in[i] = W'(b[k][i]);
      end else if (fill == 1) begin
        row_in[i] = (k >= N) ? W'(5) : '0;
        col_in[i] = (k >= N) ? W'(5) : '0;
      end else if (fill == 2) begin
        row_in[i] = W'($urandom);
        col_in[i] = W'($urandom);
      end else begin
        row_in[i] = '0;
        col_in[i] = '0;
      end
    end
  endtask

  // One operation. Returns at the negedge in the DONE cycle (or after an abort).
  task automatic run_op(input string tag, input mat_t a, input mat_t b, input int fill,
                        input bit inject, input int abort_cyc);
    int done_at  = -1;
    int busy_cnt = 0;
    int late_done;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(negedge clk);
      start = inject && (n == 3);
      drive_lanes(a, b, n - 1, fill);
      if (abort_cyc >= 0 && n == abort_cyc + 1) rst_n = 1'b0;
      if (abort_cyc >= 0 && n == abort_cyc + 2) begin
        check({tag, "_abort_busy"}, 64'(busy), 64'(0));
        check({tag, "_abort_done"}, 64'(done), 64'(0));
        check_zero({tag, "_abort"});
        rst_n     = 1'b1;
        late_done = 0;
        for (int m = 0; m < 12; m++) begin
          @(negedge clk);
          if (done) late_done++;
        end
        check({tag, "_abort_no_done"}, 64'(late_done), 64'(0));
        return;
      end
      if (busy) busy_cnt++;
      if (done) done_at = n;
    end
    check({tag, "_done_latency"}, 64'(done_at), 64'(8));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(3 * N - 2));
    check_result(tag, a, b);
    if (inject) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_start_ignored"}, 64'(busy), 64'(0));
      @(negedge clk);
      check({tag, "_still_idle"}, 64'(busy), 64'(0));
      check({tag, "_single_done"}, 64'(done), 64'(0));
      check_result({tag, "_after"}, a, b);
    end
  endtask

  task automatic idle_hold(input string tag, input mat_t a, input mat_t b);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'(0));
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
    check_result({tag, "_held"}, a, b);
  endtask

  initial begin
    mat_t a_seq;
    mat_t ra;
    mat_t rb;

    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      row_in[i] = '0;
      col_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check_zero("reset");
    rst_n = 1'b1;

    a_seq = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};

    run_op("ident", a_seq, ident(1), 0, 1'b0, -1);
    idle_hold("ident", a_seq, ident(1));

    run_op("minneg", fill_mat(-32768), fill_mat(-32768), 0, 1'b0, -1);
    check("minneg_value", 64'(result[1][2]), 64'(34'd3221225472));
    idle_hold("minneg", fill_mat(-32768), fill_mat(-32768));

    ra = rand_mat();
    rb = rand_mat();
    run_op("rand_clean", ra, rb, 0, 1'b0, -1);
    idle_hold("rand_clean", ra, rb);
    run_op("rand_hold5", ra, rb, 1, 1'b0, -1);
    idle_hold("rand_hold5", ra, rb);
    run_op("rand_junk", ra, rb, 2, 1'b0, -1);
    idle_hold("rand_junk", ra, rb);

    ra = rand_mat();
    rb = rand_mat();
    run_op("inject", ra, rb, 2, 1'b1, -1);

    ra = rand_mat();
    rb = rand_mat();
    run_op("abort", ra, rb, 0, 1'b0, 3);
    run_op("post_abort", fill_mat(2), fill_mat(2), 0, 1'b0, -1);
    idle_hold("post_abort", fill_mat(2), fill_mat(2));

    run_op("b2b_first", a_seq, ident(1), 2, 1'b0, -1);
    run_op("b2b_second", a_seq, ident(2), 2, 1'b0, -1);
    idle_hold("b2b_second", a_seq, ident(2));

    for (int r = 0; r < 4; r++) begin
      ra = rand_mat();
      rb = rand_mat();
      run_op($sformatf("rand_%0d", r), ra, rb, r % 3, 1'b0, -1);
    end
    idle_hold("rand_last", ra, rb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
